// File: rtl/edge_arb_pkg_amisha.sv
// Shared types, defaults and the round-robin pick helper for the edge event arbiter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package edge_arb_pkg_amisha;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_IDX_W = 2;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Round-robin search over up to 16 channels. The search starts at
    // (last+1) mod n and ascends with wrap. Returns {found, idx[3:0]}.
    function automatic logic [4:0] rr_pick(input logic [15:0] pend,
                                           input logic [3:0]  last,
                                           input int          n);
        logic       found;
        logic [3:0] idx;
        int         c;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            c = (int'(last) + k) % n;
            if ((k <= n) && !found && pend[c[3:0]]) begin
                found = 1'b1;
                idx   = c[3:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/edge_pending_cell_amisha.sv
// Per-channel rising-edge detector with a one-deep pending flag.
// Latency: a rise seen before edge k shows as pending after edge k; drop flag is combinational.
// Backpressure: none; a rise on an already-pending, uncleared channel raises o_drop.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_level level input;
//        i_enable gates edge capture; i_clear consumes the pending event;
//        o_pending registered flag; o_drop edge lost this cycle.
module edge_pending_cell_amisha (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_pending,
    output logic o_drop
);
    import edge_arb_pkg_amisha::*;

    logic r_level_q;
    logic r_pending;
    logic w_rise;

    // level_q keeps tracking even while disabled, so edges during disable vanish.
    assign w_rise    = i_level & ~r_level_q & i_enable;
    assign o_drop    = w_rise & r_pending & ~i_clear;
    assign o_pending = r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_q <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_level_q <= i_level;
            // A rise wins over a same-cycle clear: the new event stays pending.
            if (w_rise)
                r_pending <= 1'b1;
            else if (i_clear)
                r_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter_amisha.sv
// Collects rising edges on N_CH levels and serialises them round-robin onto one valid/ready port.
// Latency: edge -> pending one cycle, pending -> ev_valid one more cycle; one event per cycle after.
// Backpressure: ev_ch held while ev_ready=0; further edges on a pending channel are dropped and counted.
// Ports: clk_amisha, reset_n_amisha (async, active-low); level_amisha, enable_amisha inputs;
//        ev_valid_amisha/ev_ch_amisha/ev_ready_amisha event handshake;
//        pending_amisha flags; drop_amisha pulse; drop_cnt_amisha saturating lost-edge count.
module edge_event_arbiter_amisha
    import edge_arb_pkg_amisha::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_amisha,
    input  logic             reset_n_amisha,
    input  logic [N_CH-1:0]  level_amisha,
    input  logic             enable_amisha,
    output logic             ev_valid_amisha,
    output logic [IDX_W-1:0] ev_ch_amisha,
    input  logic             ev_ready_amisha,
    output logic [N_CH-1:0]  pending_amisha,
    output logic             drop_amisha,
    output logic [CNT_W-1:0] drop_cnt_amisha
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ev_valid;
    logic [IDX_W-1:0]   r_ev_ch;
    logic [IDX_W-1:0]   w_ch_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_lg_nxt;
    logic               r_drop;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W+4:0]   w_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [N_CH-1:0]    w_pending;
    logic [N_CH-1:0]    w_drop;
    logic [N_CH-1:0]    w_clear;
    logic               w_hs;
    logic [15:0]        w_pend_ext;
    logic [3:0]         w_last_ext;
    logic [4:0]         w_pick;

    assign w_hs = r_ev_valid & ev_ready_amisha;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_clear[i] = w_hs && (r_ev_ch == IDX_W'(i));
        edge_pending_cell_amisha u_cell (
            .i_clk     (clk_amisha),
            .i_rst_n   (reset_n_amisha),
            .i_level   (level_amisha[i]),
            .i_enable  (enable_amisha),
            .i_clear   (w_clear[i]),
            .o_pending (w_pending[i]),
            .o_drop    (w_drop[i])
        );
    end

    // Arbitration sees only registered pending; on a handshake the granted
    // bit is masked so the next pick can go out back-to-back.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ev_ch;
        w_lg_nxt    = r_last_grant;
        w_pend_ext  = '0;
        w_last_ext  = '0;
        w_pick      = '0;
        if (r_state == ST_IDLE) begin
            w_pend_ext[N_CH-1:0]  = w_pending;
            w_last_ext[IDX_W-1:0] = r_last_grant;
            w_pick = rr_pick(w_pend_ext, w_last_ext, N_CH);
            if (w_pick[4]) begin
                w_state_nxt = ST_OFFER;
                w_ch_nxt    = w_pick[IDX_W-1:0];
            end
        end else if (w_hs) begin
            w_lg_nxt              = r_ev_ch;
            w_pend_ext[N_CH-1:0]  = w_pending & ~w_clear;
            w_last_ext[IDX_W-1:0] = r_ev_ch;
            w_pick = rr_pick(w_pend_ext, w_last_ext, N_CH);
            if (w_pick[4])
                w_ch_nxt = w_pick[IDX_W-1:0];
            else
                w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            r_ev_valid   <= 1'b0;
            r_ev_ch      <= '0;
            r_last_grant <= IDX_W'(N_CH - 1);
        end else begin
            r_ev_valid   <= (w_state_nxt == ST_OFFER);
            r_ev_ch      <= w_ch_nxt;
            r_last_grant <= w_lg_nxt;
        end
    end

    // Several channels can drop in one cycle; add them all, then clamp.
    always_comb begin
        w_sum = {5'b0, r_drop_cnt};
        for (int i = 0; i < N_CH; i++)
            w_sum = w_sum + {{(CNT_W+4){1'b0}}, w_drop[i]};
        if (w_sum > {5'b0, {CNT_W{1'b1}}})
            w_cnt_nxt = {CNT_W{1'b1}};
        else
            w_cnt_nxt = w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop     <= |w_drop;
            r_drop_cnt <= w_cnt_nxt;
        end
    end

    assign ev_valid_amisha = r_ev_valid;
    assign ev_ch_amisha    = r_ev_ch;
    assign pending_amisha  = w_pending;
    assign drop_amisha     = r_drop;
    assign drop_cnt_amisha = r_drop_cnt;

endmodule

// File: tb/tb_edge_event_arbiter_amisha.sv
// Directed bench for edge_event_arbiter_amisha (N_CH=4, CNT_W=2 so saturation is reachable).
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: ev_ready driven directly by the stimulus sequence.
module tb_edge_event_arbiter_amisha;

    logic       clk_amisha = 1'b0;
    logic       reset_n_amisha;
    logic [3:0] level_amisha;
    logic       enable_amisha;
    logic       ev_valid_amisha;
    logic [1:0] ev_ch_amisha;
    logic       ev_ready_amisha;
    logic [3:0] pending_amisha;
    logic       drop_amisha;
    logic [1:0] drop_cnt_amisha;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_amisha = ~clk_amisha;

    edge_event_arbiter_amisha #(.N_CH(4), .IDX_W(2), .CNT_W(2)) u_dut (
        .clk_amisha      (clk_amisha),
        .reset_n_amisha  (reset_n_amisha),
        .level_amisha    (level_amisha),
        .enable_amisha   (enable_amisha),
        .ev_valid_amisha (ev_valid_amisha),
        .ev_ch_amisha    (ev_ch_amisha),
        .ev_ready_amisha (ev_ready_amisha),
        .pending_amisha  (pending_amisha),
        .drop_amisha     (drop_amisha),
        .drop_cnt_amisha (drop_cnt_amisha)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_amisha);
        #1;
    endtask

    task automatic do_reset();
        reset_n_amisha = 1'b0;
        step();
        step();
        reset_n_amisha = 1'b1;
    endtask

    initial begin
        reset_n_amisha  = 1'b0;
        level_amisha    = 4'b0001;
        enable_amisha   = 1'b1;
        ev_ready_amisha = 1'b0;

        // 1: level high across reset -> exactly one event on channel 0
        do_reset();
        check("rst_valid", ev_valid_amisha, 0);
        check("rst_ch", ev_ch_amisha, 0);
        check("rst_pend", pending_amisha, 4'b0000);
        check("rst_drop", drop_amisha, 0);
        check("rst_cnt", drop_cnt_amisha, 0);
        step();
        check("t1_pend", pending_amisha, 4'b0001);
        check("t1_valid0", ev_valid_amisha, 0);
        step();
        check("t1_valid", ev_valid_amisha, 1);
        check("t1_ch", ev_ch_amisha, 0);
        ev_ready_amisha = 1'b1;
        step();
        check("t1_pend_clr", pending_amisha, 4'b0000);
        check("t1_idle", ev_valid_amisha, 0);
        step();
        check("t1_no_repeat", ev_valid_amisha, 0);

        // 2: simultaneous rise on 0,1,3 -> back-to-back 0,1,3
        level_amisha = 4'b0000;
        do_reset();
        level_amisha = 4'b1011;
        step();
        check("t2_pend", pending_amisha, 4'b1011);
        step();
        check("t2_v0", ev_valid_amisha, 1);
        check("t2_ch0", ev_ch_amisha, 0);
        step();
        check("t2_v1", ev_valid_amisha, 1);
        check("t2_ch1", ev_ch_amisha, 1);
        check("t2_pend1", pending_amisha, 4'b1010);
        step();
        check("t2_v3", ev_valid_amisha, 1);
        check("t2_ch3", ev_ch_amisha, 3);
        step();
        check("t2_idle", ev_valid_amisha, 0);
        check("t2_pend_clr", pending_amisha, 4'b0000);

        // 3: stall channel 2 for 10 cycles, then a second rise drops once
        ev_ready_amisha = 1'b0;
        level_amisha = 4'b1111;
        step();
        check("t3_pend", pending_amisha, 4'b0100);
        step();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_v", ev_valid_amisha, 1);
            check("t3_hold_ch", ev_ch_amisha, 2);
            step();
        end
        level_amisha = 4'b1011;
        step();
        check("t3_nodrop_fall", drop_amisha, 0);
        level_amisha = 4'b1111;
        step();
        check("t3_drop", drop_amisha, 1);
        check("t3_cnt", drop_cnt_amisha, 1);
        step();
        check("t3_drop_pulse", drop_amisha, 0);
        check("t3_cnt_hold", drop_cnt_amisha, 1);
        check("t3_ch_still", ev_ch_amisha, 2);
        ev_ready_amisha = 1'b1;
        step();
        check("t3_drained", ev_valid_amisha, 0);
        ev_ready_amisha = 1'b0;

        // 4: repeated 4-channel drops saturate the 2-bit counter at 3
        level_amisha = 4'b0000;
        step();
        level_amisha = 4'b1111;
        step();
        check("t4_pend_all", pending_amisha, 4'b1111);
        check("t4_cnt_pre", drop_cnt_amisha, 1);
        level_amisha = 4'b0000;
        step();
        level_amisha = 4'b1111;
        step();
        check("t4_drop", drop_amisha, 1);
        check("t4_sat", drop_cnt_amisha, 3);
        level_amisha = 4'b0000;
        step();
        level_amisha = 4'b1111;
        step();
        check("t4_sat_nowrap", drop_cnt_amisha, 3);
        ev_ready_amisha = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t4_drain_pend", pending_amisha, 4'b0000);
        check("t4_drain_idle", ev_valid_amisha, 0);
        ev_ready_amisha = 1'b0;

        // 5: edge during disable is lost silently; pending channel 3 still drains
        level_amisha = 4'b0000;
        do_reset();
        level_amisha = 4'b1000;
        step();
        check("t5_pend3", pending_amisha, 4'b1000);
        enable_amisha = 1'b0;
        level_amisha = 4'b1010;
        step();
        check("t5_pend_dis", pending_amisha, 4'b1000);
        check("t5_v", ev_valid_amisha, 1);
        check("t5_ch3", ev_ch_amisha, 3);
        enable_amisha = 1'b1;
        step();
        check("t5_pend_en", pending_amisha, 4'b1000);
        check("t5_cnt", drop_cnt_amisha, 0);
        check("t5_drop", drop_amisha, 0);
        ev_ready_amisha = 1'b1;
        step();
        check("t5_pend_clr", pending_amisha, 4'b0000);
        check("t5_idle", ev_valid_amisha, 0);
        step();
        check("t5_no_ch1", ev_valid_amisha, 0);
        ev_ready_amisha = 1'b0;

        // 6: 1 ns async reset pulse mid-offer
        level_amisha = 4'b1000;
        step();
        level_amisha = 4'b1010;
        step();
        check("t6_pend1", pending_amisha, 4'b0010);
        step();
        check("t6_v", ev_valid_amisha, 1);
        check("t6_ch1", ev_ch_amisha, 1);
        level_amisha = 4'b0000;
        #3;
        reset_n_amisha = 1'b0;
        #1;
        check("t6_async_v", ev_valid_amisha, 0);
        check("t6_async_pend", pending_amisha, 4'b0000);
        reset_n_amisha = 1'b1;
        ev_ready_amisha = 1'b1;
        step();
        step();
        step();
        check("t6_post_v", ev_valid_amisha, 0);
        check("t6_post_pend", pending_amisha, 4'b0000);
        check("t6_post_cnt", drop_cnt_amisha, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
